// File: rtl/pairing_host_ctrl.sv
// Host-side sequencer driving the bit-serial register-file port of a pairing core.
// Optional run watchdog enabled by defining PAIRING_CTRL_TIMEOUT_EN.
module pairing_host_ctrl #(
  parameter int WIDTH          = 198,
  parameter int ADDR_W         = 6,
  parameter int TIMEOUT_CYCLES = 2**20
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [WIDTH-1:0]  cmd_wdata,
  output logic              rsp_valid,
  output logic [WIDTH-1:0]  rsp_data,
  output logic              run_done,
  output logic              busy,
  output logic              error,
  output logic              core_reset,
  output logic              core_sel,
  output logic [ADDR_W-1:0] core_addr,
  output logic              core_update,
  output logic              core_ready,
  output logic              core_i,
  output logic              core_w,
  input  logic              core_o,
  input  logic              core_done
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  localparam logic [1:0] OP_WR  = 2'b00;
  localparam logic [1:0] OP_RD  = 2'b01;
  localparam logic [1:0] OP_RUN = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_LOAD,
    S_SHIFT,
    S_COMMIT,
    S_RESP,
    S_RUNRST,
    S_RUNWAIT
  } state_e;

  state_e            state_q, state_d;
  logic              op_wr_q, op_wr_d;
  logic [WIDTH-1:0]  sr_q, sr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              done_q;
  logic              done_rise;
  logic              tmo_hit;

  logic              cmd_ready_q, cmd_ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0]  rsp_data_q, rsp_data_d;
  logic              run_done_q, run_done_d;
  logic              busy_q, busy_d;
  logic              error_q, error_d;
  logic              core_reset_q, core_reset_d;
  logic              core_sel_q, core_sel_d;
  logic [ADDR_W-1:0] core_addr_q, core_addr_d;
  logic              core_update_q, core_update_d;
  logic              core_ready_q, core_ready_d;
  logic              core_i_q, core_i_d;
  logic              core_w_q, core_w_d;

  assign done_rise = core_done & ~done_q;

`ifdef PAIRING_CTRL_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  logic [TO_W-1:0] to_q, to_d;

  always_comb begin
    to_d = '0;
    if (state_q == S_RUNWAIT) to_d = to_q + 1'b1;
  end

  assign tmo_hit = (state_q == S_RUNWAIT) && (to_q == TO_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) to_q <= '0;
    else        to_q <= to_d;
  end
`else
  logic unused_tmo;
  assign unused_tmo = (TIMEOUT_CYCLES == 0);
  assign tmo_hit    = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    op_wr_d      = op_wr_q;
    sr_d         = sr_q;
    cnt_d        = cnt_q;
    rsp_data_d   = rsp_data_q;
    error_d      = error_q;
    core_reset_d = core_reset_q;
    core_addr_d  = core_addr_q;
    rsp_valid_d  = 1'b0;
    run_done_d   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          unique case (cmd_op)
            OP_WR, OP_RD: begin
              state_d     = S_PREP;
              op_wr_d     = (cmd_op == OP_WR);
              sr_d        = cmd_wdata;
              core_addr_d = cmd_addr;
            end
            OP_RUN: begin
              state_d      = S_RUNRST;
              error_d      = 1'b0;
              core_reset_d = 1'b1;
            end
            default: ;
          endcase
        end
      end
      S_PREP: begin
        state_d = S_LOAD;
      end
      S_LOAD: begin
        state_d = S_SHIFT;
        cnt_d   = '0;
      end
      S_SHIFT: begin
        cnt_d = cnt_q + 1'b1;
        // one register serves both directions: LSB out, core_o in at MSB
        sr_d  = {(op_wr_q ? 1'b0 : core_o), sr_q[WIDTH-1:1]};
        if (cnt_q == LAST) begin
          if (op_wr_q) begin
            state_d = S_COMMIT;
          end else begin
            state_d     = S_RESP;
            rsp_valid_d = 1'b1;
            rsp_data_d  = {core_o, sr_q[WIDTH-1:1]};
          end
        end
      end
      S_COMMIT: begin
        state_d = S_IDLE;
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      S_RUNRST: begin
        state_d      = S_RUNWAIT;
        core_reset_d = 1'b0;
      end
      S_RUNWAIT: begin
        if (done_rise) begin
          state_d    = S_IDLE;
          run_done_d = 1'b1;
        end else if (tmo_hit) begin
          state_d      = S_IDLE;
          run_done_d   = 1'b1;
          error_d      = 1'b1;
          core_reset_d = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // a write forces the core FSM silent before touching its registers
    if (state_d == S_PREP && op_wr_d) core_reset_d = 1'b1;

    cmd_ready_d   = (state_d == S_IDLE);
    busy_d        = (state_d != S_IDLE);
    core_sel_d    = state_d inside {S_PREP, S_LOAD, S_SHIFT, S_COMMIT, S_RESP};
    core_update_d = (state_d == S_LOAD);
    core_ready_d  = (state_d == S_SHIFT);
    core_w_d      = (state_d == S_COMMIT);
    core_i_d      = (state_d == S_SHIFT) && op_wr_d && sr_d[0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      op_wr_q       <= 1'b0;
      sr_q          <= '0;
      cnt_q         <= '0;
      done_q        <= 1'b0;
      cmd_ready_q   <= 1'b1;
      rsp_valid_q   <= 1'b0;
      rsp_data_q    <= '0;
      run_done_q    <= 1'b0;
      busy_q        <= 1'b0;
      error_q       <= 1'b0;
      core_reset_q  <= 1'b1;
      core_sel_q    <= 1'b0;
      core_addr_q   <= '0;
      core_update_q <= 1'b0;
      core_ready_q  <= 1'b0;
      core_i_q      <= 1'b0;
      core_w_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      op_wr_q       <= op_wr_d;
      sr_q          <= sr_d;
      cnt_q         <= cnt_d;
      done_q        <= core_done;
      cmd_ready_q   <= cmd_ready_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_data_q    <= rsp_data_d;
      run_done_q    <= run_done_d;
      busy_q        <= busy_d;
      error_q       <= error_d;
      core_reset_q  <= core_reset_d;
      core_sel_q    <= core_sel_d;
      core_addr_q   <= core_addr_d;
      core_update_q <= core_update_d;
      core_ready_q  <= core_ready_d;
      core_i_q      <= core_i_d;
      core_w_q      <= core_w_d;
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;
  assign run_done    = run_done_q;
  assign busy        = busy_q;
  assign error       = error_q;
  assign core_reset  = core_reset_q;
  assign core_sel    = core_sel_q;
  assign core_addr   = core_addr_q;
  assign core_update = core_update_q;
  assign core_ready  = core_ready_q;
  assign core_i      = core_i_q;
  assign core_w      = core_w_q;

endmodule

// File: tb/tb_pairing_host_ctrl.sv
// Directed bench for pairing_host_ctrl with a behavioural serial register-file core.
// Timeout checks are active when PAIRING_CTRL_TIMEOUT_EN is defined.
module tb_pairing_host_ctrl;

  localparam int W  = 198;
  localparam int AW = 6;
  localparam int BUDGET = 2000;

  localparam logic [W-1:0] D1 =
    198'h21181940120548aa020568aa65a5989609251595a89a44598;
  localparam logic [W-1:0] D2 =
    198'h0560aa60a0954548aa615069885106a16281162056945a084;
  localparam logic [W-1:0] R9 =
    198'h0123456789abcdef_fedcba9876543210_55aa;
  localparam logic [10:0] RST_CTL = 11'b100_0010_0000;

  logic          clk = 1'b0;
  logic          reset;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_op;
  logic [AW-1:0] cmd_addr;
  logic [W-1:0]  cmd_wdata;
  logic          rsp_valid;
  logic [W-1:0]  rsp_data;
  logic          run_done;
  logic          busy;
  logic          error;
  logic          core_reset;
  logic          core_sel;
  logic [AW-1:0] core_addr;
  logic          core_update;
  logic          core_ready;
  logic          core_i;
  logic          core_w;
  logic          core_o;
  logic          core_done;

  always #5 clk = ~clk;

  pairing_host_ctrl #(
    .WIDTH(W),
    .ADDR_W(AW),
    .TIMEOUT_CYCLES(64)
  ) dut (
    .clk(clk),
    .reset(reset),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_op(cmd_op),
    .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid),
    .rsp_data(rsp_data),
    .run_done(run_done),
    .busy(busy),
    .error(error),
    .core_reset(core_reset),
    .core_sel(core_sel),
    .core_addr(core_addr),
    .core_update(core_update),
    .core_ready(core_ready),
    .core_i(core_i),
    .core_w(core_w),
    .core_o(core_o),
    .core_done(core_done)
  );

  logic [10:0] ctl;
  assign ctl = {cmd_ready, rsp_valid, run_done, busy, error, core_reset,
                core_sel, core_update, core_ready, core_i, core_w};

  // behavioural core: serial regfile plus a run that finishes after 500 cycles
  logic [W-1:0] mem [64];
  logic [W-1:0] msr;
  int           m_cnt;
  logic         m_init;
  logic         m_never;

  always @(posedge clk) begin
    if (m_init) begin
      mem[3] <= '0;
      mem[5] <= D2;
      mem[9] <= '0;
    end
    if (core_sel && core_update) msr <= mem[core_addr];
    else if (core_sel && core_ready) msr <= {core_i, msr[W-1:1]};
    if (core_sel && core_w) mem[core_addr] <= msr;
    if (core_reset) begin
      m_cnt     <= 0;
      core_done <= 1'b0;
    end else begin
      if (m_cnt < 1000) m_cnt <= m_cnt + 1;
      if (!m_never && m_cnt == 499) begin
        core_done <= 1'b1;
        mem[9]    <= R9;
      end
    end
  end

  assign core_o = msr[0];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [W-1:0] got,
                     input logic [W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  int n_upd, n_rdy, n_w, n_rsp, n_rd, n_sel, n_busy, n_excl;
  int lat, rsp_c, rsp_t, rd_c, done_c;
  logic [W-1:0] ibits;

  task automatic issue(input logic [1:0] op, input logic [AW-1:0] addr,
                       input logic [W-1:0] data, input int abort_at);
    int  k;
    bit  fin;
    k = 0;
    while (!cmd_ready && k < BUDGET) begin
      @(negedge clk);
      k++;
    end
    if (!cmd_ready) chk("ready_wait", W'(cmd_ready), W'(1));
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_addr  = addr;
    cmd_wdata = data;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    n_upd = 0; n_rdy = 0; n_w = 0; n_rsp = 0; n_rd = 0;
    n_sel = 0; n_busy = 0; n_excl = 0;
    lat = -1; rsp_c = -1; rsp_t = -1; rd_c = -1; done_c = -1;
    ibits = '0;
    fin = 1'b0;
    for (int c = 0; c < BUDGET && !fin; c++) begin
      @(negedge clk);
      if (core_update) n_upd++;
      if (core_ready) begin
        n_rdy++;
        ibits = {core_i, ibits[W-1:1]};
      end
      if (core_w) n_w++;
      if (int'(core_update) + int'(core_ready) + int'(core_w) > 1) n_excl++;
      if (core_sel) n_sel++;
      if (busy) n_busy++;
      if (rsp_valid) begin
        n_rsp++;
        rsp_c = c;
        rsp_t = cyc;
      end
      if (run_done) begin
        n_rd++;
        rd_c = c;
      end
      if (core_done && done_c < 0) done_c = c;
      if (abort_at >= 0 && n_rdy == abort_at) begin
        reset = 1'b0;
        #1;
        chk("abort_ctl", W'(ctl), W'(RST_CTL));
        chk("abort_rsp_data", rsp_data, '0);
        chk("abort_addr", W'(core_addr), '0);
        repeat (3) begin
          @(negedge clk);
          if (core_w) n_w++;
        end
        reset = 1'b1;
        lat = c;
        fin = 1'b1;
      end else if (cmd_ready) begin
        lat = c;
        fin = 1'b1;
      end
    end
    if (!fin) chk("cmd_timeout", W'(0), W'(1));
  endtask

  int t1;

  initial begin
    reset     = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_addr  = '0;
    cmd_wdata = '0;
    m_init    = 1'b1;
    m_never   = 1'b0;
    repeat (3) @(negedge clk);
    m_init = 1'b0;
    chk("reset_ctl", W'(ctl), W'(RST_CTL));
    chk("reset_rsp_data", rsp_data, '0);
    chk("reset_addr", W'(core_addr), '0);
    reset = 1'b1;
    @(negedge clk);

    issue(2'b00, 6'd3, D1, -1);
    chk("wr_update", W'(n_upd), W'(1));
    chk("wr_ready", W'(n_rdy), W'(198));
    chk("wr_bits", ibits, D1);
    chk("wr_w", W'(n_w), W'(1));
    chk("wr_lat", W'(lat), W'(201));
    chk("wr_sel", W'(n_sel), W'(201));
    chk("wr_excl", W'(n_excl), W'(0));
    chk("wr_addr", W'(core_addr), W'(3));
    chk("wr_core_reset", W'(core_reset), W'(1));
    chk("wr_mem", mem[3], D1);

    issue(2'b01, 6'd5, '0, -1);
    chk("rd5_rsp", W'(n_rsp), W'(1));
    chk("rd5_rsp_lat", W'(rsp_c), W'(200));
    chk("rd5_data", rsp_data, D2);
    chk("rd5_w", W'(n_w), W'(0));

    issue(2'b10, '0, '0, -1);
    chk("run_done_cnt", W'(n_rd), W'(1));
    chk("run_done_lat", W'(rd_c), W'(done_c + 1));
    chk("run_core_reset", W'(core_reset), W'(0));
    chk("run_sel", W'(n_sel), W'(0));
    chk("run_error", W'(error), W'(0));
    issue(2'b01, 6'd9, '0, -1);
    chk("rd9_data", rsp_data, R9);
    chk("rd9_core_reset", W'(core_reset), W'(0));

`ifdef PAIRING_CTRL_TIMEOUT_EN
    m_never = 1'b1;
    issue(2'b10, '0, '0, -1);
    chk("tmo_lat", W'(lat), W'(65));
    chk("tmo_run_done", W'(n_rd), W'(1));
    chk("tmo_error", W'(error), W'(1));
    chk("tmo_core_reset", W'(core_reset), W'(1));
    m_never = 1'b0;
    issue(2'b10, '0, '0, -1);
    chk("tmo_error_clr", W'(error), W'(0));
    chk("tmo_rerun_done", W'(n_rd), W'(1));
`endif

    issue(2'b00, 6'd3, ~D1, 100);
    chk("abort_w", W'(n_w), W'(0));
    chk("abort_mem", mem[3], D1);
    issue(2'b01, 6'd3, '0, -1);
    chk("abort_rd_rsp", W'(n_rsp), W'(1));
    chk("abort_rd_data", rsp_data, D1);

    issue(2'b11, 6'd7, D2, -1);
    chk("rsv_sel", W'(n_sel), W'(0));
    chk("rsv_busy", W'(n_busy), W'(0));
    chk("rsv_lat", W'(lat), W'(0));
    chk("rsv_upd", W'(n_upd + n_rdy + n_w), W'(0));
    issue(2'b01, 6'd5, '0, -1);
    t1 = rsp_t;
    chk("b2b_rsp1", W'(n_rsp), W'(1));
    chk("b2b_data1", rsp_data, D2);
    issue(2'b01, 6'd9, '0, -1);
    chk("b2b_rsp2", W'(n_rsp), W'(1));
    chk("b2b_data2", rsp_data, R9);
    chk("b2b_gap", W'(rsp_t - t1 - 1), W'(201));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no end expected finish");
    $fatal(1);
  end

endmodule
